// File: rtl/dot_product_engine.sv
// Dot-product engine: streams two signed vectors out of a dual-port RAM and
// accumulates their element-wise products through a two-stage multiply/accumulate pipe.

module dot_product_mac #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 40
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  input  logic                        in_vld,
  input  logic signed [WIDTH-1:0]     a,
  input  logic signed [WIDTH-1:0]     b,
  output logic signed [ACC_WIDTH-1:0] acc
);
  localparam int PW = 2*WIDTH;

  logic                 prod_vld;
  logic [1:0]           vld_pipe;
  logic signed [PW-1:0] prod;

  // [0]: RAM data valid this cycle, [1]: product register holds a real element
  assign vld_pipe = {prod_vld, in_vld};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_vld <= 1'b0;
      prod     <= '0;
      acc      <= '0;
    end else begin
      prod_vld <= vld_pipe[0];
      if (vld_pipe[0]) prod <= a * b;
      if (clr)              acc <= '0;
      else if (vld_pipe[1]) acc <= acc + {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
    end
  end
endmodule

module dot_product_engine #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 7,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [ADDR_WIDTH:0]         len,
  input  logic [ADDR_WIDTH-1:0]       base_a,
  input  logic [ADDR_WIDTH-1:0]       base_b,
  output logic [ADDR_WIDTH-1:0]       addr_a,
  output logic [ADDR_WIDTH-1:0]       addr_b,
  input  logic signed [WIDTH-1:0]     dout_a,
  input  logic signed [WIDTH-1:0]     dout_b,
  output logic                        busy,
  output logic                        done,
  output logic signed [ACC_WIDTH-1:0] result
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [ADDR_WIDTH:0] LEN_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                        state;
  logic [ADDR_WIDTH-1:0]         cnt;
  logic [ADDR_WIDTH-1:0]         len_m1;
  logic                          drain_cnt;
  logic                          rd_vld;
  logic [ADDR_WIDTH:0]           len_sat;
  logic                          accept;
  logic signed [ACC_WIDTH-1:0]   acc;

  assign len_sat = (len > LEN_MAX) ? LEN_MAX : len;
  assign accept  = (state == IDLE) && start;

  // Accumulator is cleared on every accepted start, so a len=0 run reports 0 too.
  dot_product_mac #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (accept),
    .in_vld (rd_vld),
    .a      (dout_a),
    .b      (dout_b),
    .acc    (acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_a    <= '0;
      addr_b    <= '0;
      cnt       <= '0;
      len_m1    <= '0;
      drain_cnt <= 1'b0;
      rd_vld    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
    end else begin
      done   <= 1'b0;
      // an address driven in ISSUE returns data in the following cycle
      rd_vld <= (state == ISSUE);
      case (state)
        IDLE: begin
          if (start) begin
            busy   <= 1'b1;
            result <= '0;
            if (len_sat == '0) begin
              state <= DONE;
            end else begin
              addr_a <= base_a;
              addr_b <= base_b;
              cnt    <= '0;
              len_m1 <= ADDR_WIDTH'(len_sat - 1'b1);
              state  <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (cnt == len_m1) begin
            drain_cnt <= 1'b0;
            state     <= DRAIN;
          end else begin
            addr_a <= addr_a + 1'b1;
            addr_b <= addr_b + 1'b1;
            cnt    <= cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt) state <= DONE;
          else           drain_cnt <= 1'b1;
        end
        DONE: begin
          result <= acc;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dot_product_engine.sv
// Bench for dot_product_engine: behavioural dual-port RAM, reference dot-product
// model feeding a result scoreboard, latency and handshake checks per scenario.

module tb_dot_product_engine;
  localparam int W = 16, AW = 7, ACCW = 40;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [AW:0] len = '0;
  logic [AW-1:0] base_a = '0, base_b = '0;
  logic [AW-1:0] addr_a, addr_b;
  logic signed [W-1:0] dout_a, dout_b;
  logic busy, done;
  logic signed [ACCW-1:0] result;

  logic signed [W-1:0] mem [0:127];
  logic [AW-1:0] ra_q = '0, rb_q = '0;

  int checks = 0, errors = 0;
  longint exp_q[$];

  dot_product_engine #(.WIDTH(W), .ADDR_WIDTH(AW), .ACC_WIDTH(ACCW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .base_a(base_a), .base_b(base_b),
    .addr_a(addr_a), .addr_b(addr_b), .dout_a(dout_a), .dout_b(dout_b),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // RAM: address registered at the edge, read data combinational from it
  always @(posedge clk) begin
    ra_q <= addr_a;
    rb_q <= addr_b;
  end
  assign dout_a = mem[ra_q];
  assign dout_b = mem[rb_q];

  function automatic longint model(input int ba, input int bb, input int n);
    longint s = 0;
    if (n > 128) n = 128;
    for (int k = 0; k < n; k++)
      s += longint'(mem[(ba + k) % 128]) * longint'(mem[(bb + k) % 128]);
    return s;
  endfunction

  // Called at a negedge; start is seen by the next rising edge (E0).
  task automatic launch(input int ba, input int bb, input int n, input bit push);
    logic [31:0] ba_v, bb_v, n_v;
    ba_v = ba; bb_v = bb; n_v = n;
    base_a = ba_v[AW-1:0];
    base_b = bb_v[AW-1:0];
    len    = n_v[AW:0];
    start  = 1'b1;
    if (push) exp_q.push_back(model(ba, bb, n));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts cycles after E0 until done; also notes any cycle with busy low before it.
  task automatic wait_done(output int cyc, output bit busy_ok);
    cyc = 0; busy_ok = 1'b1;
    while (!done && cyc < 400) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (result !== '0)   begin errors++; $display("FAIL reset_result got %0d want 0", result); end
    checks++; if (addr_a !== '0 || addr_b !== '0)
      begin errors++; $display("FAIL reset_addr got %0d/%0d want 0/0", addr_a, addr_b); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int cyc; bit bok; longint e;
    for (int k = 0; k < 4; k++) begin mem[k] = 16'(k + 1); mem[64 + k] = 16'(k + 5); end
    launch(0, 64, 4, 1);
    wait_done(cyc, bok);
    checks++; if (cyc !== 7) begin errors++; $display("FAIL basic_latency got %0d want 7", cyc); end
    checks++; if (!bok)      begin errors++; $display("FAIL basic_busy dropped before done"); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got %b want 0", busy); end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL basic_result no expected entry"); end
    else begin e = exp_q.pop_front();
      if (result !== e[ACCW-1:0]) begin errors++; $display("FAIL basic_result got %0d want %0d", result, e); end
    end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", done); end
  endtask

  task automatic test_signed();
    int cyc; bit bok; longint e;
    mem[10] = -16'sd32768; mem[11] = -16'sd32768;
    mem[20] = -16'sd32768; mem[21] = 16'sd32767;
    for (int n = 2; n >= 1; n--) begin
      launch(10, 20, n, 1);
      wait_done(cyc, bok);
      checks++; if (cyc !== n + 3) begin errors++; $display("FAIL signed_latency got %0d want %0d", cyc, n + 3); end
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL signed_result no expected entry"); end
      else begin e = exp_q.pop_front();
        if (result !== e[ACCW-1:0]) begin errors++; $display("FAIL signed_result got %0d want %0d", result, e); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_full();
    int cyc; bit bok; longint e;
    int lens [2] = '{128, 200};
    for (int k = 0; k < 128; k++) mem[k] = 16'sd32767;
    foreach (lens[i]) begin
      launch(i * 5, i * 90, lens[i], 1);
      wait_done(cyc, bok);
      checks++; if (cyc !== 131) begin errors++; $display("FAIL full_latency len=%0d got %0d want 131", lens[i], cyc); end
      checks++; if (!bok) begin errors++; $display("FAIL full_busy len=%0d dropped before done", lens[i]); end
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL full_result no expected entry"); end
      else begin e = exp_q.pop_front();
        if (result !== e[ACCW-1:0]) begin errors++; $display("FAIL full_result got %0d want %0d", result, e); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wrap();
    int cyc; bit bok; longint e;
    mem[126] = 16'sd1; mem[127] = 16'sd2; mem[0] = 16'sd3; mem[1] = 16'sd4;
    launch(126, 126, 4, 1);
    wait_done(cyc, bok);
    checks++; if (cyc !== 7) begin errors++; $display("FAIL wrap_latency got %0d want 7", cyc); end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL wrap_result no expected entry"); end
    else begin e = exp_q.pop_front();
      if (result !== e[ACCW-1:0]) begin errors++; $display("FAIL wrap_result got %0d want %0d", result, e); end
    end
    checks++; if (addr_a !== 7'd1) begin errors++; $display("FAIL wrap_last_addr got %0d want 1", addr_a); end
    @(negedge clk);
  endtask

  task automatic test_len0();
    int cyc; bit bok; longint e;
    logic [AW-1:0] pa, pb;
    pa = addr_a; pb = addr_b;
    launch(40, 50, 0, 1);
    wait_done(cyc, bok);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL len0_latency got %0d want 1", cyc); end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL len0_result no expected entry"); end
    else begin e = exp_q.pop_front();
      if (result !== e[ACCW-1:0]) begin errors++; $display("FAIL len0_result got %0d want %0d", result, e); end
    end
    checks++; if (addr_a !== pa || addr_b !== pb)
      begin errors++; $display("FAIL len0_addr got %0d/%0d want %0d/%0d", addr_a, addr_b, pa, pb); end
    @(negedge clk);
  endtask

  task automatic test_ignore_start();
    int cyc; bit bok; longint e; bit extra;
    for (int k = 0; k < 4; k++) begin mem[k] = 16'(k + 1); mem[64 + k] = 16'(k + 5); end
    launch(0, 64, 4, 1);
    base_a = 7'd100; base_b = 7'd110; len = 8'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, bok);
    checks++; if (cyc + 1 !== 7) begin errors++; $display("FAIL ignore_latency got %0d want 7", cyc + 1); end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL ignore_result no expected entry"); end
    else begin e = exp_q.pop_front();
      if (result !== e[ACCW-1:0]) begin errors++; $display("FAIL ignore_result got %0d want %0d", result, e); end
    end
    extra = 1'b0;
    repeat (10) begin @(negedge clk); if (done || busy) extra = 1'b1; end
    checks++; if (extra) begin errors++; $display("FAIL ignore_extra_run got activity want none"); end
  endtask

  task automatic test_back_to_back();
    int cyc; bit bok; longint e;
    mem[30] = 16'sd2; mem[31] = -16'sd3; mem[32] = 16'sd5;
    mem[40] = 16'sd7; mem[41] = 16'sd11; mem[42] = -16'sd13;
    launch(30, 40, 3, 1);
    wait_done(cyc, bok);
    checks++; if (cyc !== 6) begin errors++; $display("FAIL b2b_first_latency got %0d want 6", cyc); end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_first_result no expected entry"); end
    else begin e = exp_q.pop_front();
      if (result !== e[ACCW-1:0]) begin errors++; $display("FAIL b2b_first_result got %0d want %0d", result, e); end
    end
    launch(40, 30, 2, 1);
    wait_done(cyc, bok);
    checks++; if (cyc !== 5) begin errors++; $display("FAIL b2b_second_latency got %0d want 5", cyc); end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_second_result no expected entry"); end
    else begin e = exp_q.pop_front();
      if (result !== e[ACCW-1:0]) begin errors++; $display("FAIL b2b_second_result got %0d want %0d", result, e); end
    end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    int cyc; bit bok; longint e; bit seen;
    for (int k = 0; k < 10; k++) begin mem[k] = 16'(k + 2); mem[64 + k] = 16'(3 * k + 1); end
    launch(0, 64, 10, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0)
      begin errors++; $display("FAIL midrst_ctrl got busy=%b done=%b want 0/0", busy, done); end
    checks++; if (result !== '0) begin errors++; $display("FAIL midrst_result got %0d want 0", result); end
    checks++; if (addr_a !== '0 || addr_b !== '0)
      begin errors++; $display("FAIL midrst_addr got %0d/%0d want 0/0", addr_a, addr_b); end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin @(negedge clk); if (done) seen = 1'b1; end
    checks++; if (seen) begin errors++; $display("FAIL midrst_spurious_done got 1 want 0"); end
    mem[10] = 16'sd3; mem[20] = -16'sd4;
    launch(10, 20, 1, 1);
    wait_done(cyc, bok);
    checks++; if (cyc !== 4) begin errors++; $display("FAIL midrst_fresh_latency got %0d want 4", cyc); end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL midrst_fresh_result no expected entry"); end
    else begin e = exp_q.pop_front();
      if (result !== e[ACCW-1:0]) begin errors++; $display("FAIL midrst_fresh_result got %0d want %0d", result, e); end
    end
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 128; k++) mem[k] = '0;
    test_reset();
    test_basic();
    test_signed();
    test_full();
    test_wrap();
    test_len0();
    test_ignore_start();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
